// File: rtl/register_loading_scoreboard.sv
// Per-register table of outstanding loads: issue allocates, writeback retires,
// and decode reads pending flags plus the stored tag/data on several ports.
module register_loading_scoreboard #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 5,
  parameter int READ_PORTS = 2,
  parameter int CNT_WIDTH  = 2,
  parameter int BYPASS     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [DEPTH-1:0]            issue_index,
  input  logic [WIDTH-1:0]            issue_data,
  input  logic                        retire_valid,
  input  logic [DEPTH-1:0]            retire_index,
  input  logic [READ_PORTS*DEPTH-1:0] read_index,
  output logic [READ_PORTS-1:0]       read_pending,
  output logic [READ_PORTS*WIDTH-1:0] read_data,
  output logic                        any_pending,
  output logic                        underflow_error
);

  localparam int NUM_WORDS = 2 ** DEPTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt    [NUM_WORDS];
  logic [WIDTH-1:0]     data_q [NUM_WORDS];

  logic issue_fire;
  logic retire_hit;
  logic retire_dec;
  logic same_index;

  // Entry 0 is x0: it never allocates, never retires and never raises an error.
  assign issue_ready = (issue_index == '0) || (cnt[issue_index] != CNT_MAX) ||
                       (retire_valid && (retire_index == issue_index));
  assign issue_fire  = issue_valid && issue_ready && (issue_index != '0);
  assign retire_hit  = retire_valid && (retire_index != '0);
  assign retire_dec  = retire_hit && (cnt[retire_index] != '0);
  assign same_index  = issue_fire && retire_hit && (issue_index == retire_index);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        cnt[i]    <= '0;
        data_q[i] <= '0;
      end
      underflow_error <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      if (issue_fire) begin
        data_q[issue_index] <= issue_data;
      end
      // An issue and retire on the same entry cancel out in the count.
      if (!same_index) begin
        if (issue_fire) begin
          cnt[issue_index] <= cnt[issue_index] + CNT_WIDTH'(1);
        end
        if (retire_dec) begin
          cnt[retire_index] <= cnt[retire_index] - CNT_WIDTH'(1);
        end
      end
      if (retire_hit && (cnt[retire_index] == '0)) begin
        underflow_error <= 1'b1;
      end
    end
  end

  // Reads come from registered state; a same-cycle issue overrides when bypass is on.
  always_comb begin
    read_pending = '0;
    read_data    = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (cnt[read_index[p*DEPTH +: DEPTH]] != '0) begin
        read_pending[p]              = 1'b1;
        read_data[p*WIDTH +: WIDTH]  = data_q[read_index[p*DEPTH +: DEPTH]];
      end
      if ((BYPASS != 0) && issue_fire && (read_index[p*DEPTH +: DEPTH] == issue_index)) begin
        read_pending[p]              = 1'b1;
        read_data[p*WIDTH +: WIDTH]  = issue_data;
      end
    end
  end

  always_comb begin
    any_pending = 1'b0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      any_pending = any_pending | (cnt[i] != '0);
    end
  end

endmodule

// File: tb/tb_register_loading_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// count-per-register reference model.
module tb_register_loading_scoreboard;

  localparam int W  = 32;
  localparam int D  = 5;
  localparam int RP = 2;
  localparam int MAXC = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            issue_valid;
  logic            issue_ready;
  logic [D-1:0]    issue_index;
  logic [W-1:0]    issue_data;
  logic            retire_valid;
  logic [D-1:0]    retire_index;
  logic [RP*D-1:0] read_index;
  logic [RP-1:0]   read_pending;
  logic [RP*W-1:0] read_data;
  logic            any_pending;
  logic            underflow_error;

  int n_checks = 0;
  int n_fail   = 0;

  int          mcnt  [32];
  logic [31:0] mdata [32];
  bit          merr;

  register_loading_scoreboard #(
    .WIDTH(W), .DEPTH(D), .READ_PORTS(RP), .CNT_WIDTH(2), .BYPASS(1)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_index(issue_index), .issue_data(issue_data),
    .retire_valid(retire_valid), .retire_index(retire_index),
    .read_index(read_index), .read_pending(read_pending), .read_data(read_data),
    .any_pending(any_pending), .underflow_error(underflow_error)
  );

  always #5 clk = ~clk;

  // Reference model: loads outstanding per register, last stored word, sticky error.
  function automatic bit exp_ready();
    return (issue_index == 0) || (mcnt[issue_index] < MAXC) ||
           (retire_valid && retire_index == issue_index);
  endfunction

  function automatic bit exp_fire();
    return issue_valid && exp_ready() && (issue_index != 0);
  endfunction

  function automatic bit exp_pend(int p);
    int idx = int'(read_index[p*D +: D]);
    if (exp_fire() && idx == int'(issue_index)) return 1'b1;
    return mcnt[idx] != 0;
  endfunction

  function automatic logic [31:0] exp_rdata(int p);
    int idx = int'(read_index[p*D +: D]);
    if (exp_fire() && idx == int'(issue_index)) return issue_data;
    return (mcnt[idx] != 0) ? mdata[idx] : 32'h0;
  endfunction

  function automatic bit exp_any();
    for (int i = 0; i < 32; i++) if (mcnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    reset = 0; flush = 0; issue_valid = 0; issue_index = 0; issue_data = 0;
    retire_valid = 0; retire_index = 0;
  endtask

  task automatic set_reads(input int a, input int b);
    read_index = {5'(b), 5'(a)};
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic tick();
    bit fire = exp_fire();
    int ii = int'(issue_index);
    int ri = int'(retire_index);
    bit rhit = retire_valid && ri != 0;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin mcnt[i] = 0; mdata[i] = 0; end
      merr = 0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
    end else begin
      if (rhit && mcnt[ri] == 0) merr = 1;
      if (fire) mdata[ii] = issue_data;
      if (!(fire && rhit && ri == ii)) begin
        if (fire) mcnt[ii]++;
        if (rhit && mcnt[ri] > 0) mcnt[ri]--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1; tick(); idle();
    set_reads(5, 7); issue_index = 5; #1;
    n_checks++; if (read_pending !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_pending: got %b expected 00", read_pending); end
    n_checks++; if (read_data !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 0", read_data); end
    n_checks++; if (any_pending !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_any: got %b expected 0", any_pending); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", issue_ready); end
    n_checks++; if (underflow_error !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", underflow_error); end
  endtask

  task automatic test_bypass();
    idle(); set_reads(5, 7);
    issue_valid = 1; issue_index = 5; issue_data = 32'hDEAD_BEEF; #1;
    n_checks++; if (read_pending[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL bypass_pending: got %b expected 1", read_pending[0]); end
    n_checks++; if (read_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL bypass_data: got %h expected deadbeef", read_data[31:0]); end
    n_checks++; if (any_pending !== 1'b0) begin n_fail++; $display("[TB] FAIL bypass_any_same: got %b expected 0", any_pending); end
    tick(); idle(); #1;
    n_checks++; if (any_pending !== 1'b1) begin n_fail++; $display("[TB] FAIL bypass_any_next: got %b expected 1", any_pending); end
    retire_valid = 1; retire_index = 5; #1;
    n_checks++; if (read_pending[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL retire_no_bypass: got %b expected 1", read_pending[0]); end
    tick(); idle(); #1;
    n_checks++; if (read_pending[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL retire_pending: got %b expected 0", read_pending[0]); end
    n_checks++; if (read_data[31:0] !== 32'h0) begin n_fail++; $display("[TB] FAIL retire_data: got %h expected 0", read_data[31:0]); end
  endtask

  task automatic test_saturate();
    idle(); set_reads(9, 0);
    for (int k = 0; k < 3; k++) begin
      issue_valid = 1; issue_index = 9; issue_data = 32'h900 + k; tick();
    end
    idle(); issue_valid = 1; issue_index = 9; issue_data = 32'hBAD; #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_ready: got %b expected 0", issue_ready); end
    n_checks++; if (read_data[31:0] !== 32'h902) begin n_fail++; $display("[TB] FAIL sat_stall_data: got %h expected 902", read_data[31:0]); end
    tick(); #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_hold_ready: got %b expected 0", issue_ready); end
    retire_valid = 1; retire_index = 9; issue_data = 32'h9AA; #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_swap_ready: got %b expected 1", issue_ready); end
    tick(); idle(); issue_index = 9; #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_swap_cnt: got %b expected 0", issue_ready); end
    n_checks++; if (read_data[31:0] !== 32'h9AA) begin n_fail++; $display("[TB] FAIL sat_swap_data: got %h expected 9aa", read_data[31:0]); end
    for (int k = 0; k < 3; k++) begin
      retire_valid = 1; retire_index = 9; tick(); idle(); #1;
      n_checks++;
      if (read_pending[0] !== (k < 2)) begin n_fail++; $display("[TB] FAIL sat_drain_%0d: got %b expected %b", k, read_pending[0], k < 2); end
    end
  endtask

  task automatic test_x0();
    idle(); set_reads(0, 0);
    issue_valid = 1; issue_index = 0; issue_data = 32'h1234; #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL x0_ready: got %b expected 1", issue_ready); end
    n_checks++; if (read_pending !== 2'b00) begin n_fail++; $display("[TB] FAIL x0_bypass: got %b expected 00", read_pending); end
    tick(); idle(); #1;
    n_checks++; if (read_pending !== 2'b00 || read_data !== 64'h0) begin n_fail++; $display("[TB] FAIL x0_pending: got %b/%h expected 00/0", read_pending, read_data); end
    retire_valid = 1; retire_index = 0; tick(); idle(); #1;
    n_checks++; if (underflow_error !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_err: got %b expected 0", underflow_error); end
  endtask

  task automatic test_underflow();
    idle(); retire_valid = 1; retire_index = 12; tick(); idle(); #1;
    n_checks++; if (underflow_error !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_set: got %b expected 1", underflow_error); end
    issue_valid = 1; issue_index = 2; issue_data = 32'h22; tick();
    idle(); retire_valid = 1; retire_index = 2; tick(); idle(); #1;
    n_checks++; if (underflow_error !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_sticky: got %b expected 1", underflow_error); end
    flush = 1; tick(); idle(); #1;
    n_checks++; if (underflow_error !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_flush: got %b expected 1", underflow_error); end
    issue_valid = 1; issue_index = 6; tick(); tick(); idle();
    reset = 1; tick(); idle(); set_reads(6, 6); #1;
    n_checks++; if (underflow_error !== 1'b0 || read_pending !== 2'b00) begin n_fail++; $display("[TB] FAIL uf_reset: got %b/%b expected 0/00", underflow_error, read_pending); end
    retire_valid = 1; retire_index = 6; tick(); idle(); #1;
    n_checks++; if (underflow_error !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_after_reset: got %b expected 1", underflow_error); end
    reset = 1; tick(); idle();
  endtask

  task automatic test_flush();
    idle(); set_reads(3, 31);
    issue_valid = 1; issue_index = 3; issue_data = 32'h33; tick();
    issue_index = 31; issue_data = 32'h3131; tick(); idle(); #1;
    n_checks++; if (read_pending !== 2'b11 || read_data !== {32'h3131, 32'h33}) begin n_fail++; $display("[TB] FAIL flush_pre: got %b/%h expected 11/0000313100000033", read_pending, read_data); end
    flush = 1; issue_valid = 1; issue_index = 4; issue_data = 32'h44; tick(); idle(); #1;
    n_checks++; if (read_pending !== 2'b00 || read_data !== 64'h0) begin n_fail++; $display("[TB] FAIL flush_clear: got %b/%h expected 00/0", read_pending, read_data); end
    n_checks++; if (any_pending !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_any: got %b expected 0", any_pending); end
    set_reads(4, 4); #1;
    n_checks++; if (read_pending !== 2'b00) begin n_fail++; $display("[TB] FAIL flush_issue_dropped: got %b expected 00", read_pending); end
  endtask

  task automatic test_random();
    idle(); reset = 1; tick(); idle();
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 99) < 2);
      flush        = ($urandom_range(0, 99) < 4);
      issue_valid  = ($urandom_range(0, 99) < 60);
      issue_index  = 5'($urandom_range(0, 7));
      issue_data   = $urandom;
      retire_valid = ($urandom_range(0, 99) < 45);
      retire_index = 5'($urandom_range(0, 7));
      if (retire_valid && issue_valid && retire_index == issue_index && mcnt[retire_index] == 0)
        retire_valid = 0;
      set_reads($urandom_range(0, 7), $urandom_range(0, 7));
      #1;
      n_checks++; if (any_pending !== exp_any()) begin n_fail++; $display("[TB] FAIL rnd_any@%0d: got %b expected %b", n, any_pending, exp_any()); end
      n_checks++; if (underflow_error !== merr) begin n_fail++; $display("[TB] FAIL rnd_err@%0d: got %b expected %b", n, underflow_error, merr); end
      if (!reset && !flush) begin
        n_checks++; if (issue_ready !== exp_ready()) begin n_fail++; $display("[TB] FAIL rnd_ready@%0d: got %b expected %b", n, issue_ready, exp_ready()); end
        for (int p = 0; p < RP; p++) begin
          n_checks++;
          if (read_pending[p] !== exp_pend(p) || read_data[p*W +: W] !== exp_rdata(p)) begin
            n_fail++;
            $display("[TB] FAIL rnd_read%0d@%0d: got %b/%h expected %b/%h", p, n, read_pending[p], read_data[p*W +: W], exp_pend(p), exp_rdata(p));
          end
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mcnt[i] = 0; mdata[i] = 0; end
    merr = 0;
    idle(); read_index = '0;
    test_reset();
    test_bypass();
    test_saturate();
    test_x0();
    test_underflow();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
